// File: rtl/dmem_responder.sv
// Word-organised data memory behind a valid/ready request/response port; one request in flight.
// Latency: response valid LATENCY cycles after accept. Backpressure: response held until i_rsp_ready.
// Optional DMEM_RESPONDER_STATS_EN adds saturating read/write/error counters.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_wen,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_mask,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
`ifdef DMEM_RESPONDER_STATS_EN
    ,
    output logic [31:0] o_stat_reads,
    output logic [31:0] o_stat_writes,
    output logic [31:0] o_stat_errs
`endif
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [1:0]  rst_sync;
    logic        rst_n;
    logic [31:0] offset;
    logic [AW-1:0] index;
    logic        err;
    logic        accept;
    logic [31:0] bmask;
    logic [31:0] mem [DEPTH_WORDS];

    // Reset asserts asynchronously but leaves on a clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign offset = i_req_addr - BASE_ADDR;
    assign index  = offset[AW+1:2];
    assign err    = (i_req_addr[1:0] != 2'b00) || (offset >= SPAN) || (i_req_mask == 4'b0000);
    assign bmask  = {{8{i_req_mask[3]}}, {8{i_req_mask[2]}}, {8{i_req_mask[1]}}, {8{i_req_mask[0]}}};

    assign o_req_ready = (state == IDLE);
    assign o_rsp_valid = (state == RESP);
    assign accept      = i_req_valid && o_req_ready;

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (i_req_valid) begin
                    state_nxt = (LATENCY > 1) ? WAIT : RESP;
                    cnt_nxt   = LOAD;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            RESP: begin
                if (i_rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Array has no reset; writes are gated off while the block is held in reset.
    always_ff @(posedge i_clk) begin
        if (rst_n && accept && i_req_wen && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (i_req_mask[b]) mem[index][8*b +: 8] <= i_req_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rsp_rdata <= 32'h0;
            o_rsp_err   <= 1'b0;
        end else if (accept) begin
            o_rsp_err   <= err;
            o_rsp_rdata <= (i_req_wen || err) ? 32'h0 : (mem[index] & bmask);
        end
    end

`ifdef DMEM_RESPONDER_STATS_EN
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_stat_reads  <= 32'h0;
            o_stat_writes <= 32'h0;
            o_stat_errs   <= 32'h0;
        end else if (accept) begin
            if (err) begin
                if (o_stat_errs != 32'hFFFF_FFFF) o_stat_errs <= o_stat_errs + 32'd1;
            end else if (i_req_wen) begin
                if (o_stat_writes != 32'hFFFF_FFFF) o_stat_writes <= o_stat_writes + 32'd1;
            end else begin
                if (o_stat_reads != 32'hFFFF_FFFF) o_stat_reads <= o_stat_reads + 32'd1;
            end
        end
    end
`endif

endmodule
